// File: rtl/io_mem_responder_if.sv
// Core data-side bus and UART byte links of the I/O responder.
// The responder attaches through the slave modport; the core/UART side uses master.
interface io_mem_responder_if;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [3:0]  wea;
  logic        rd_en;
  logic        instr_stop;
  logic [31:0] io_rdata;
  logic        io_sel_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output mem_adr, mem_wdata, wea, rd_en, instr_stop, tx_ready, rx_data, rx_valid,
    input  io_rdata, io_sel_q, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  mem_adr, mem_wdata, wea, rd_en, instr_stop, tx_ready, rx_data, rx_valid,
    output io_rdata, io_sel_q, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_mem_responder.sv
// Memory-mapped I/O responder: UART TX FIFO, RX holding register, cycle/instret counters.
// Define IO_COUNTERS_EN to build the counters at 0x10/0x14 and the 0x18 clear.
module io_mem_responder #(
  parameter logic [31:0] IO_BASE       = 32'h8000_0000,
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  io_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_FIFO_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CNTCLR = 8'h18;

  logic [7:0]    r_mem [TX_FIFO_DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          r_rx_full;
  logic [7:0]    r_rx_byte;
  logic [31:0]   r_rdata;
  logic          r_sel_q;

  logic          w_hit;
  logic          w_wr;
  logic [7:0]    w_off;
  logic          w_tx_valid;
  logic          w_not_full;
  logic          w_pop;
  logic          w_push;
  logic          w_rx_pop;
  logic          w_rx_cap;
  logic [31:0]   w_rdmux;
  logic [31:0]   w_cyc;
  logic [31:0]   w_ins;

  assign w_hit      = (bus.mem_adr[31:28] == IO_BASE[31:28]);
  assign w_wr       = |bus.wea;
  assign w_off      = bus.mem_adr[7:0];
  assign w_tx_valid = (r_count != '0);
  assign w_not_full = (r_count < DEPTH_C);
  assign w_pop      = w_tx_valid & bus.tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push     = w_hit & w_wr & (w_off == OFF_TXDATA) & (w_not_full | w_pop);
  assign w_rx_pop   = w_hit & bus.rd_en & (w_off == OFF_RXDATA) & r_rx_full;
  assign w_rx_cap   = bus.rx_valid & ~r_rx_full;

  // TX FIFO storage and pointers; storage is cleared so tx_data is 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < TX_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.mem_wdata[7:0];
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // RX holding register; capture and CPU pop are mutually exclusive by construction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_full <= 1'b0;
      r_rx_byte <= '0;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end else if (w_rx_cap) begin
      r_rx_full <= 1'b1;
      r_rx_byte <= bus.rx_data;
    end
  end

`ifdef IO_COUNTERS_EN
  logic [31:0] r_cyc;
  logic [31:0] r_ins;
  logic        w_cnt_clr;

  assign w_cnt_clr = w_hit & w_wr & (w_off == OFF_CNTCLR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else if (w_cnt_clr) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (!bus.instr_stop) begin
        r_ins <= r_ins + 32'd1;
      end
    end
  end

  assign w_cyc = r_cyc;
  assign w_ins = r_ins;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = bus.instr_stop;
  assign w_cyc        = '0;
  assign w_ins        = '0;
`endif

  always_comb begin
    w_rdmux = '0;
    if (w_hit) begin
      case (w_off)
        OFF_STATUS: w_rdmux = {30'd0, r_rx_full, w_not_full};
        OFF_RXDATA: w_rdmux = {24'd0, r_rx_byte};
        OFF_CYCLE:  w_rdmux = w_cyc;
        OFF_INSTR:  w_rdmux = w_ins;
        default:    w_rdmux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_sel_q <= 1'b0;
    end else begin
      r_rdata <= w_rdmux;
      r_sel_q <= w_hit;
    end
  end

  logic w_unused;
  assign w_unused = ^{bus.mem_adr[27:8], bus.mem_wdata[31:8]};

  assign bus.io_rdata = r_rdata;
  assign bus.io_sel_q = r_sel_q;
  assign bus.tx_data  = r_mem[r_rptr];
  assign bus.tx_valid = w_tx_valid;
  assign bus.rx_ready = ~r_rx_full;

endmodule

// File: tb/tb_io_mem_responder.sv
// Directed plus randomized bench for io_mem_responder against a queue-based reference model.
// Honours IO_COUNTERS_EN the same way as the design build.
module tb_io_mem_responder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  io_mem_responder_if bus();

  io_mem_responder #(
    .IO_BASE       (32'h8000_0000),
    .TX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state: FIFO contents as a queue, RX flag/byte, counters.
  byte unsigned txq[$];
  bit           m_rx_full;
  logic [7:0]   m_rx_byte;
  logic [31:0]  m_cyc;
  logic [31:0]  m_ins;

  logic [31:0] adr_tab [9] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008,
                               32'h8000_0010, 32'h8000_0014, 32'h8000_0018,
                               32'h8000_0020, 32'h1000_0010, 32'h8000_0108};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    m_rx_full = 1'b0;
    m_rx_byte = 8'h00;
    m_cyc     = 32'd0;
    m_ins     = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    if (adr[31:28] != 4'h8) return 32'd0;
    case (adr[7:0])
      8'h00: return {30'd0, m_rx_full, (txq.size() < DEPTH)};
      8'h04: return {24'd0, m_rx_byte};
`ifdef IO_COUNTERS_EN
      8'h10: return m_cyc;
      8'h14: return m_ins;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One access cycle: drive, predict, clock, then compare all visible outputs.
  task automatic step(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] we,
                      input logic rd, input logic stop, input logic txr,
                      input logic rxv, input logic [7:0] rxd, output logic [31:0] rq);
    logic [31:0] exp_rd;
    bit hit, wr, pop, push;
    bus.mem_adr    = adr;
    bus.mem_wdata  = wd;
    bus.wea        = we;
    bus.rd_en      = rd;
    bus.instr_stop = stop;
    bus.tx_ready   = txr;
    bus.rx_valid   = rxv;
    bus.rx_data    = rxd;
    exp_rd = model_read(adr);
    hit  = (adr[31:28] == 4'h8);
    wr   = (we != 4'd0);
    pop  = (txq.size() != 0) && txr;
    push = hit && wr && (adr[7:0] == 8'h08) && ((txq.size() < DEPTH) || pop);
    if (pop)  void'(txq.pop_front());
    if (push) txq.push_back(wd[7:0]);
    if (hit && rd && adr[7:0] == 8'h04 && m_rx_full) m_rx_full = 1'b0;
    else if (rxv && !m_rx_full) begin
      m_rx_full = 1'b1;
      m_rx_byte = rxd;
    end
`ifdef IO_COUNTERS_EN
    if (hit && wr && adr[7:0] == 8'h18) begin
      m_cyc = 32'd0;
      m_ins = 32'd0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (!stop) m_ins = m_ins + 32'd1;
    end
`endif
    @(posedge clk);
    #1;
    check("io_rdata", bus.io_rdata, exp_rd);
    check("io_sel_q", {31'd0, bus.io_sel_q}, {31'd0, hit});
    check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, (txq.size() != 0)});
    check("rx_ready", {31'd0, bus.rx_ready}, {31'd0, !m_rx_full});
    if (txq.size() != 0) check("tx_data", {24'd0, bus.tx_data}, {24'd0, txq[0]});
    rq = bus.io_rdata;
  endtask

  task automatic idle(input logic stop, input logic txr);
    logic [31:0] rq;
    step(32'h0000_0000, 32'd0, 4'd0, 1'b0, stop, txr, 1'b0, 8'd0, rq);
  endtask

  initial begin
    logic [31:0] rq;
    logic [31:0] a;
    logic [3:0]  we;
    bus.mem_adr = '0; bus.mem_wdata = '0; bus.wea = '0; bus.rd_en = 1'b0;
    bus.instr_stop = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    model_reset();

    // Reset for three cycles.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("rst_io_rdata", bus.io_rdata, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    step(32'h8000_0000, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("rst_status", rq, 32'h1);

    // TX fill with transmitter stalled; fifth byte dropped.
    for (int i = 0; i < 5; i++)
      step(32'h8000_0008, 32'h0000_0041 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("fill_head", {24'd0, bus.tx_data}, 32'h41);
    step(32'h8000_0000, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("fill_status", rq, 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);
    check("drain_empty", {31'd0, bus.tx_valid}, 32'd0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 4; i++)
      step(32'h8000_0008, 32'h0000_0061 + 32'(i), 4'hf, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    step(32'h8000_0008, 32'h0000_0055, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, rq);
    step(32'h8000_0000, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("pushpop_full", rq, 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);

    // RX capture, blocked second byte, CPU pop.
    step(32'h0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, rq);
    check("rx_full_ready", {31'd0, bus.rx_ready}, 32'd0);
    step(32'h0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, rq);
    step(32'h8000_0004, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("rx_data", rq, 32'h0000_007E);
    check("rx_ready_back", {31'd0, bus.rx_ready}, 32'd1);

    // Counters: clear, then 10 cycles with fetch stalled on 3 of them.
    step(32'h8000_0018, 32'd0, 4'hf, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    for (int i = 0; i < 10; i++) idle(i < 3, 1'b0);
    step(32'h8000_0010, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, rq);
`ifdef IO_COUNTERS_EN
    check("cycle10", rq, 32'd10);
`else
    check("cycle_off", rq, 32'd0);
`endif
    step(32'h8000_0014, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, rq);
`ifdef IO_COUNTERS_EN
    check("instr7", rq, 32'd7);
`else
    check("instr_off", rq, 32'd0);
`endif
    step(32'h8000_0018, 32'd0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    idle(1'b0, 1'b0);
    step(32'h8000_0010, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
`ifdef IO_COUNTERS_EN
    check("cycle_after_clr", rq, 32'd1);
`else
    check("cycle_after_clr_off", rq, 32'd0);
`endif

    // Decode: unmapped offset inside region, address outside region.
    step(32'h8000_0020, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("dec_unmapped", rq, 32'd0);
    check("dec_sel_in", {31'd0, bus.io_sel_q}, 32'd1);
    step(32'h1000_0010, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("dec_outside", rq, 32'd0);
    check("dec_sel_out", {31'd0, bus.io_sel_q}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a  = adr_tab[$urandom_range(0, 8)];
      we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step(a, $urandom, we, (we == 4'd0) ? 1'($urandom_range(0, 1)) : 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rq);
    end

    // Asynchronous reset mid-operation with FIFO and RX occupied.
    step(32'h8000_0008, 32'h0000_00A5, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, rq);
    step(32'h8000_0008, 32'h0000_005A, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rq);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("async_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("async_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("async_io_rdata", bus.io_rdata, 32'd0);
    check("async_sel_q", {31'd0, bus.io_sel_q}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(32'h8000_0004, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, rq);
    check("async_rx_byte", rq, 32'd0);
    for (int i = 0; i < 40; i++) begin
      a = adr_tab[$urandom_range(0, 8)];
      step(a, $urandom, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
